// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: fetch-to-decode pipeline register with valid/ready, flush, opcode slice and stall counter.
// Define DECODE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module decode_pipe_stage #(
  parameter int PC_W        = 7,
  parameter int INSTR_W     = 32,
  parameter int OPC_LSB     = 21,
  parameter int OPC_W       = 7,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [INSTR_W-1:0]     instr_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        pc_out,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [OPC_W-1:0]       opcode_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;
  logic m_valid;
  logic accept;
  logic consume;
  assign accept     = in_valid && in_ready;
  assign consume    = m_valid && out_ready;
  assign out_valid  = m_valid;
  assign opcode_out = instr_out[OPC_LSB +: OPC_W];
`ifdef DECODE_SKID_EN
  logic               s_valid;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;
  // S only fills while M is stalled, so !s_valid is a safe registered ready
  assign in_ready = !s_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      pc_out    <= '0;
      instr_out <= '0;
      s_pc      <= '0;
      s_instr   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || consume) begin
      m_valid <= s_valid || accept;
      s_valid <= s_valid && accept;
      if (s_valid) begin
        pc_out    <= s_pc;
        instr_out <= s_instr;
      end else if (accept) begin
        pc_out    <= pc_in;
        instr_out <= instr_in;
      end
      if (s_valid && accept) begin
        s_pc    <= pc_in;
        s_instr <= instr_in;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_pc    <= pc_in;
      s_instr <= instr_in;
    end
  end
`else
  assign in_ready = out_ready || !m_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      pc_out    <= '0;
      instr_out <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= accept || (m_valid && !consume);
      if (accept) begin
        pc_out    <= pc_in;
        instr_out <= instr_in;
      end
    end
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (m_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_ONE;
  end
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed and random checks of decode_pipe_stage against an in-order queue model.
module tb_decode_pipe_stage;
  typedef struct packed {logic [6:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 1'b0, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [6:0] pc_in, pc_out, opcode_out;
  logic [31:0] instr_in, instr_out;
  logic [3:0] stall_cnt, scnt;
  ent_t q[$];
  bit last_acc;
  int vectors = 0, miscompares = 0;
  int held;

  decode_pipe_stage #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .instr_out(instr_out),
    .opcode_out(opcode_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
`ifdef DECODE_SKID_EN
    return q.size() < 2;
`else
    return out_ready || q.size() == 0;
`endif
  endfunction

  task automatic tick();
    bit acc, con;
    acc = in_valid && exp_ready();
    con = q.size() != 0 && out_ready;
    if (q.size() != 0 && !out_ready && scnt != 4'hF) scnt = scnt + 4'd1;
    @(posedge clk);
    if (con) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc) q.push_back(ent_t'{pc_in, instr_in});
    last_acc = acc && !flush;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; pc_in = '0; instr_in = '0;
    scnt = '0; q.delete();
    repeat (2) @(posedge clk);
    #1;
    vectors += 6;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); miscompares++; end
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", in_ready); miscompares++; end
    if (pc_out !== 7'h0) begin $display("FAIL reset_pc got %h want 0", pc_out); miscompares++; end
    if (instr_out !== 32'h0) begin $display("FAIL reset_instr got %h want 0", instr_out); miscompares++; end
    if (opcode_out !== 7'h0) begin $display("FAIL reset_opcode got %h want 0", opcode_out); miscompares++; end
    if (stall_cnt !== 4'h0) begin $display("FAIL reset_stall got %h want 0", stall_cnt); miscompares++; end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; pc_in = 7'(i); instr_in = 32'h0A00_0000 + (32'(i) << 21);
      tick();
      vectors += 5;
      if (out_valid !== 1'b1) begin $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); miscompares++; end
      if (pc_out !== 7'(i)) begin $display("FAIL stream_pc[%0d] got %h want %h", i, pc_out, 7'(i)); miscompares++; end
      if (opcode_out !== 7'h50 + 7'(i)) begin $display("FAIL stream_opcode[%0d] got %h want %h", i, opcode_out, 7'h50 + 7'(i)); miscompares++; end
      if (instr_out !== 32'h0A00_0000 + (32'(i) << 21)) begin $display("FAIL stream_instr[%0d] got %h", i, instr_out); miscompares++; end
      if (in_ready !== 1'b1) begin $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); miscompares++; end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin $display("FAIL stream_drain got %b want 0", out_valid); miscompares++; end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; pc_in = 7'h20; instr_in = 32'h20;
    tick();
    pc_in = 7'h21; instr_in = 32'h21; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (last_acc) begin pc_in = pc_in + 7'd1; instr_in = instr_in + 32'd1; end
    end
    vectors += 4;
    if (stall_cnt !== 4'd5) begin $display("FAIL bp_stall got %0d want 5", stall_cnt); miscompares++; end
    if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready got %b want 0", in_ready); miscompares++; end
    if (out_valid !== 1'b1) begin $display("FAIL bp_valid got %b want 1", out_valid); miscompares++; end
    if (pc_out !== 7'h20) begin $display("FAIL bp_head got %h want 20", pc_out); miscompares++; end
`ifdef DECODE_SKID_EN
    held = 2;
`else
    held = 1;
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k < held; k++) begin
      tick();
      vectors += 2;
      if (out_valid !== 1'b1) begin $display("FAIL bp_drain_valid[%0d] got %b want 1", k, out_valid); miscompares++; end
      if (pc_out !== 7'h20 + 7'(k)) begin $display("FAIL bp_drain_pc[%0d] got %h want %h", k, pc_out, 7'h20 + 7'(k)); miscompares++; end
    end
    tick();
    vectors += 2;
    if (out_valid !== 1'b0) begin $display("FAIL bp_empty got %b want 0", out_valid); miscompares++; end
    if (stall_cnt !== 4'd5) begin $display("FAIL bp_stall_hold got %0d want 5", stall_cnt); miscompares++; end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; pc_in = 7'h30; instr_in = 32'h30;
    tick();
    pc_in = 7'h31; instr_in = 32'h31;
    tick();
    flush = 1'b1; pc_in = 7'h3F; instr_in = 32'h3F;
    tick();
    flush = 1'b0;
    vectors += 3;
    if (out_valid !== 1'b0) begin $display("FAIL flush_valid got %b want 0", out_valid); miscompares++; end
    if (in_ready !== 1'b1) begin $display("FAIL flush_in_ready got %b want 1", in_ready); miscompares++; end
    if (stall_cnt !== 4'd7) begin $display("FAIL flush_stall got %0d want 7", stall_cnt); miscompares++; end
    out_ready = 1'b1; pc_in = 7'h40; instr_in = 32'h40;
    tick();
    in_valid = 1'b0;
    vectors += 2;
    if (out_valid !== 1'b1) begin $display("FAIL flush_next_valid got %b want 1", out_valid); miscompares++; end
    if (pc_out !== 7'h40) begin $display("FAIL flush_next_pc got %h want 40", pc_out); miscompares++; end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin $display("FAIL flush_after got %b want 0", out_valid); miscompares++; end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; pc_in = 7'h50; instr_in = 32'h0A20_0000;
    tick();
    pc_in = 7'h51;
    tick();
    rst_n = 1'b0;
    #2;
    q.delete(); scnt = '0;
    vectors += 6;
    if (out_valid !== 1'b0) begin $display("FAIL rmid_valid got %b want 0", out_valid); miscompares++; end
    if (in_ready !== 1'b1) begin $display("FAIL rmid_in_ready got %b want 1", in_ready); miscompares++; end
    if (pc_out !== 7'h0) begin $display("FAIL rmid_pc got %h want 0", pc_out); miscompares++; end
    if (instr_out !== 32'h0) begin $display("FAIL rmid_instr got %h want 0", instr_out); miscompares++; end
    if (opcode_out !== 7'h0) begin $display("FAIL rmid_opcode got %h want 0", opcode_out); miscompares++; end
    if (stall_cnt !== 4'h0) begin $display("FAIL rmid_stall got %h want 0", stall_cnt); miscompares++; end
    @(posedge clk);
    #1;
    rst_n = 1'b1; pc_in = 7'h52;
    tick();
    in_valid = 1'b0;
    vectors += 2;
    if (out_valid !== 1'b1) begin $display("FAIL rmid_first_valid got %b want 1", out_valid); miscompares++; end
    if (pc_out !== 7'h52) begin $display("FAIL rmid_first_pc got %h want 52", pc_out); miscompares++; end
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1; in_valid = 1'b1; pc_in = 7'h60; instr_in = 32'h60;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15) begin
        vectors++;
        if (stall_cnt !== 4'(k)) begin $display("FAIL sat_stall[%0d] got %0d want %0d", k, stall_cnt, k); miscompares++; end
      end
    end
    vectors += 2;
    if (stall_cnt !== 4'd15) begin $display("FAIL sat_hold got %0d want 15", stall_cnt); miscompares++; end
    if (pc_out !== 7'h60) begin $display("FAIL sat_pc got %h want 60", pc_out); miscompares++; end
    out_ready = 1'b1;
    tick();
    vectors += 2;
    if (out_valid !== 1'b0) begin $display("FAIL sat_drain got %b want 0", out_valid); miscompares++; end
    if (stall_cnt !== 4'd15) begin $display("FAIL sat_final got %0d want 15", stall_cnt); miscompares++; end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(9) < 6);
      out_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(49) == 0);
      pc_in = 7'($urandom);
      instr_in = $urandom;
      tick();
      vectors += 3;
      if (out_valid !== (q.size() != 0)) begin $display("FAIL rnd_valid[%0d] got %b want %b", c, out_valid, q.size() != 0); miscompares++; end
      if (in_ready !== exp_ready()) begin $display("FAIL rnd_ready[%0d] got %b want %b", c, in_ready, exp_ready()); miscompares++; end
      if (stall_cnt !== scnt) begin $display("FAIL rnd_stall[%0d] got %0d want %0d", c, stall_cnt, scnt); miscompares++; end
      if (q.size() != 0) begin
        vectors += 3;
        if (pc_out !== q[0].pc) begin $display("FAIL rnd_pc[%0d] got %h want %h", c, pc_out, q[0].pc); miscompares++; end
        if (instr_out !== q[0].instr) begin $display("FAIL rnd_instr[%0d] got %h want %h", c, instr_out, q[0].instr); miscompares++; end
        if (opcode_out !== q[0].instr[27:21]) begin $display("FAIL rnd_opcode[%0d] got %h want %h", c, opcode_out, q[0].instr[27:21]); miscompares++; end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised decode-stage pipeline register that carries the program counter and instruction from fetch into decode and extracts the opcode field. It generalises the fixed 7-bit PC / 32-bit instruction decode register with configurable widths, a valid/ready handshake with back-pressure, and synchronous flush for branch redirects. It also adds an optional two-entry skid buffer for full throughput under registered ready, and a saturating stall counter. It sits between the fetch unit and the execute-stage controller.

## Interface
- PC_W, 7, program counter width
- INSTR_W, 32, instruction width; must be ≥ OPC_LSB+OPC_W
- OPC_LSB, 21, bit position of opcode LSB within instruction
- OPC_W, 7, opcode field width
- STALL_CNT_W, 16, stall counter width
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents pc_in/instr_in
- in_ready  output  1  stage accepts input this cycle
- pc_in  input  PC_W  fetched PC
- instr_in  input  INSTR_W  fetched instruction
- flush  input  1  discard all held and incoming entries
- out_valid  output  1  pc_out/instr_out/opcode_out valid
- out_ready  input  1  downstream consumes this cycle
- pc_out  output  PC_W  registered PC
- instr_out  output  INSTR_W  registered instruction
- opcode_out  output  OPC_W  instr_out[OPC_LSB +: OPC_W]
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Accept = in_valid && in_ready; consume = out_valid && out_ready.
- Main register (M) drives outputs; opcode_out is a pure slice of M's instruction, no extra logic.
- Entries leave in arrival order; none duplicated or dropped except by flush.
- With skid (see Configuration): second register S. in_ready = !S.valid (registered).
  - Accept while M empty or consumed: load M from input (if S empty) or from S, and load S with input.
  - Accept while M full and not consumed: load S.
  - Consume with S full and no accept: M ← S, S empties.
- flush=1: at next edge M.valid=0, S.valid=0; an input accepted in the flush cycle is dropped; consume in that cycle still counts as delivered downstream.
- Payload registers are not cleared by flush; checked only when out_valid=1.
- stall_cnt increments when out_valid && !out_ready, holds at all-ones; not cleared by flush.

## Timing
- Reset (async, rst_n=0): out_valid=0, S.valid=0, pc_out=0, instr_out=0, opcode_out=0, stall_cnt=0, in_ready=1 (both modes, since out_valid=0).
- Latency: accept at edge N → out_valid=1 after edge N, visible cycle N+1.
- Throughput: one entry per cycle when out_ready held high.
- Reset asserted mid-stream: all entries lost immediately; first accept after release appears one cycle later.
- Simultaneous flush and in_valid: in_ready may be 1, but entry is discarded.
- Simultaneous accept and consume with M full, S empty: M takes input, S stays empty.

## Configuration
- DECODE_SKID_EN defined: two-entry skid buffer, in_ready is a flop output (no combinational path from out_ready), full throughput.
- Undefined: S removed; in_ready = out_ready || !out_valid (combinational); one entry of storage, still one per cycle throughput; all other behaviour identical.

## Test plan
- Reset, then stream pc=0..9, instr=0x0A0000_00+pc<<21 with out_ready=1 → outputs in order one cycle later, opcode_out equals instr[27:21], no gaps.
- Hold out_ready=0 for 5 cycles with in_valid=1 → at most 2 entries held (skid) or 1 (no skid), in_ready=0, stall_cnt=5, no loss on release.
- Assert flush with M and S full, in_valid=1 same cycle → next cycle out_valid=0, subsequent pc=0x40 emerges first.
- Assert rst_n=0 mid-stream while out_valid=1 → outputs zero immediately, in_ready=1, stall_cnt=0.
- STALL_CNT_W=4, stall 20 cycles → stall_cnt saturates at 15.
- Random valid/ready (10k cycles, both macro settings) → scoreboard matches, order preserved.
